// File: rtl/dcp_recover_if.sv
// dcp_recover_if - pixel stream bundle for the DCP recovery stage.
// The master side (upstream stages) drives the hazy pixel, syncs, transmittance and atmospheric light.
// The slave side (dcp_recover) returns the dehazed pixel stream.
// Optional macro DCP_RECOVER_BYPASS_EN adds the per-pixel i_bypass signal.

interface dcp_recover_if;
  logic [7:0] i_r;
  logic [7:0] i_g;
  logic [7:0] i_b;
  logic       i_hsync;
  logic       i_vsync;
  logic [7:0] i_transmittance;
  logic [7:0] i_dark_max;
  logic       i_data_valid;
`ifdef DCP_RECOVER_BYPASS_EN
  logic       i_bypass;
`endif
  logic [7:0] o_r;
  logic [7:0] o_g;
  logic [7:0] o_b;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_data_valid;

  modport master (
`ifdef DCP_RECOVER_BYPASS_EN
    output i_bypass,
`endif
    output i_r, i_g, i_b, i_hsync, i_vsync,
    output i_transmittance, i_dark_max, i_data_valid,
    input  o_r, o_g, o_b, o_hsync, o_vsync, o_data_valid
  );

  modport slave (
`ifdef DCP_RECOVER_BYPASS_EN
    input  i_bypass,
`endif
    input  i_r, i_g, i_b, i_hsync, i_vsync,
    input  i_transmittance, i_dark_max, i_data_valid,
    output o_r, o_g, o_b, o_hsync, o_vsync, o_data_valid
  );
endinterface

// File: rtl/dcp_recover.sv
// dcp_recover - haze-removal recovery stage: J = A + (I - A) / t per colour channel.
// The RGB/sync stream is delayed ALIGN_DLY cycles so it lines up with the transmittance,
// then a short pipe (threshold/diff, reciprocal lookup, multiply+add+clamp) produces the output
// three cycles after i_data_valid. Division is replaced by a reciprocal ROM (8.8 fixed point).
// Optional macro DCP_RECOVER_BYPASS_EN: adds i_bypass, which passes the delayed input pixel through.

module dcp_recover #(
  parameter int         ALIGN_DLY = 3,
  parameter logic [7:0] T_MIN     = 8'd26,
  parameter logic [7:0] A_RST     = 8'd255
) (
  input logic          pixelclk,
  input logic          reset,
  dcp_recover_if.slave bus
);

  localparam int DW = 26;  // {hsync, vsync, r, g, b}

  // Rounded reciprocal of t scaled by 65280 (255*256); values below the floor reuse the floor entry
  function automatic logic [11:0] recipOf(input int t);
    int tt;
    tt = (t < int'(T_MIN)) ? int'(T_MIN) : t;
    return 12'((65280 + tt / 2) / tt);
  endfunction

  logic [DW-1:0] r_dly [ALIGN_DLY];
  logic [DW-1:0] w_tap;
  logic [7:0]    w_tap_i [3];
  logic          w_tap_hs;
  logic          w_tap_vs;

  logic          r_vs_prev;
  logic [7:0]    r_a_frame;
  logic          w_vs_rise;
  logic [7:0]    w_a_cur;
  logic [7:0]    w_t_c;

  logic [7:0]        r_s0_t;
  logic signed [8:0] r_s0_diff [3];
  logic [7:0]        r_s0_a;
  logic              r_s0_valid;
  logic              r_s0_hs;
  logic              r_s0_vs;

  logic [11:0]       r_s1_recip;
  logic signed [8:0] r_s1_diff [3];
  logic [7:0]        r_s1_a;
  logic              r_s1_valid;
  logic              r_s1_hs;
  logic              r_s1_vs;

  logic [11:0]        w_rom [256];
  logic signed [21:0] w_prod [3];
  logic signed [22:0] w_sum [3];
  logic [7:0]         w_sat [3];
  logic [7:0]         w_res [3];

  logic [7:0] r_out [3];
  logic       r_o_valid;
  logic       r_o_hs;
  logic       r_o_vs;

`ifdef DCP_RECOVER_BYPASS_EN
  logic       r_s0_byp;
  logic [7:0] r_s0_i [3];
  logic       r_s1_byp;
  logic [7:0] r_s1_i [3];
`endif

  assign w_tap      = r_dly[ALIGN_DLY-1];
  assign w_tap_hs   = w_tap[25];
  assign w_tap_vs   = w_tap[24];
  assign w_tap_i[0] = w_tap[23:16];
  assign w_tap_i[1] = w_tap[15:8];
  assign w_tap_i[2] = w_tap[7:0];

  // The pixel that carries the vsync rising edge already uses the freshly latched A
  assign w_vs_rise = w_tap_vs & ~r_vs_prev;
  assign w_a_cur   = w_vs_rise ? bus.i_dark_max : r_a_frame;
  assign w_t_c     = (bus.i_transmittance < T_MIN) ? T_MIN : bus.i_transmittance;

  for (genvar gi = 0; gi < 256; gi++) begin : g_rom
    assign w_rom[gi] = recipOf(gi);
  end

  // Alignment delay line for RGB and syncs
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < ALIGN_DLY; k++) r_dly[k] <= '0;
    end else begin
      r_dly[0] <= {bus.i_hsync, bus.i_vsync, bus.i_r, bus.i_g, bus.i_b};
      for (int k = 1; k < ALIGN_DLY; k++) r_dly[k] <= r_dly[k-1];
    end
  end

  // Per-frame atmospheric light, captured on the delayed vsync rising edge
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      r_vs_prev <= 1'b0;
      r_a_frame <= A_RST;
    end else begin
      r_vs_prev <= w_tap_vs;
      r_a_frame <= w_a_cur;
    end
  end

  // S0: floor the transmittance and form the signed I - A difference per channel
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      r_s0_t     <= '0;
      r_s0_a     <= '0;
      r_s0_valid <= 1'b0;
      r_s0_hs    <= 1'b0;
      r_s0_vs    <= 1'b0;
      for (int c = 0; c < 3; c++) r_s0_diff[c] <= '0;
    end else begin
      r_s0_t     <= w_t_c;
      r_s0_a     <= w_a_cur;
      r_s0_valid <= bus.i_data_valid;
      r_s0_hs    <= w_tap_hs;
      r_s0_vs    <= w_tap_vs;
      for (int c = 0; c < 3; c++)
        r_s0_diff[c] <= $signed({1'b0, w_tap_i[c]}) - $signed({1'b0, w_a_cur});
    end
  end

  // S1: reciprocal lookup, everything else rides along
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      r_s1_recip <= '0;
      r_s1_a     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_hs    <= 1'b0;
      r_s1_vs    <= 1'b0;
      for (int c = 0; c < 3; c++) r_s1_diff[c] <= '0;
    end else begin
      r_s1_recip <= w_rom[r_s0_t];
      r_s1_a     <= r_s0_a;
      r_s1_valid <= r_s0_valid;
      r_s1_hs    <= r_s0_hs;
      r_s1_vs    <= r_s0_vs;
      for (int c = 0; c < 3; c++) r_s1_diff[c] <= r_s0_diff[c];
    end
  end

`ifdef DCP_RECOVER_BYPASS_EN
  // Bypass flag and untouched input pixel travel with the pipe
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      r_s0_byp <= 1'b0;
      r_s1_byp <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        r_s0_i[c] <= '0;
        r_s1_i[c] <= '0;
      end
    end else begin
      r_s0_byp <= bus.i_bypass;
      r_s1_byp <= r_s0_byp;
      for (int c = 0; c < 3; c++) begin
        r_s0_i[c] <= w_tap_i[c];
        r_s1_i[c] <= r_s0_i[c];
      end
    end
  end
`endif

  // S2/S3: scale the difference by 1/t, drop the 8 fraction bits (floor), add A back and clamp
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      w_prod[c] = '0;
      w_sum[c]  = '0;
      w_sat[c]  = '0;
      w_res[c]  = '0;
    end
    for (int c = 0; c < 3; c++) begin
      w_prod[c] = 22'(r_s1_diff[c]) * $signed({10'b0, r_s1_recip});
      w_sum[c]  = 23'(w_prod[c] >>> 8) + $signed({15'b0, r_s1_a});
      if (w_sum[c] < 0)
        w_sat[c] = 8'd0;
      else if (w_sum[c] > 23'sd255)
        w_sat[c] = 8'd255;
      else
        w_sat[c] = w_sum[c][7:0];
`ifdef DCP_RECOVER_BYPASS_EN
      w_res[c] = r_s1_byp ? r_s1_i[c] : w_sat[c];
`else
      w_res[c] = w_sat[c];
`endif
    end
  end

  // Output register: pixel updates only on valid, so invalid cycles hold the last result
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      r_o_valid <= 1'b0;
      r_o_hs    <= 1'b0;
      r_o_vs    <= 1'b0;
      for (int c = 0; c < 3; c++) r_out[c] <= '0;
    end else begin
      r_o_valid <= r_s1_valid;
      r_o_hs    <= r_s1_hs;
      r_o_vs    <= r_s1_vs;
      if (r_s1_valid) begin
        for (int c = 0; c < 3; c++) r_out[c] <= w_res[c];
      end
    end
  end

  assign bus.o_r          = r_out[0];
  assign bus.o_g          = r_out[1];
  assign bus.o_b          = r_out[2];
  assign bus.o_hsync      = r_o_hs;
  assign bus.o_vsync      = r_o_vs;
  assign bus.o_data_valid = r_o_valid;

endmodule

// File: tb/tb_dcp_recover.sv
// tb_dcp_recover - directed vector bench for dcp_recover.
// Each table row is one pixel as it enters the RGB side; the bench itself skews transmittance,
// dark max, valid (and bypass) by the alignment delay and expects the row back at the output
// two cycles after its transmittance cycle. Build with DCP_RECOVER_BYPASS_EN to add bypass rows.

module tb_dcp_recover;

  typedef struct {
    logic       vs;
    logic       hs;
    logic       valid;
    logic       byp;
    logic [7:0] dm;
    logic [7:0] t;
    logic [7:0] r, g, b;
    logic [7:0] er, eg, eb;
  } vec_t;

  logic pixelclk = 1'b0;
  logic reset;

  dcp_recover_if bus();

  dcp_recover dut (
    .pixelclk (pixelclk),
    .reset    (reset),
    .bus      (bus)
  );

  // 100 MHz-ish pixel clock
  always #5 pixelclk = ~pixelclk;

  vec_t       hist [6];
  vec_t       seg1 [$];
  vec_t       segPre [$];
  vec_t       segPost [$];
  int         nApplied = 0;
  int         nMiss = 0;
  int         stepNo = 0;
  logic [7:0] lastR, lastG, lastB;

  function automatic vec_t mkv(input logic vs, input logic hs, input logic valid, input logic byp,
                               input logic [7:0] dm, input logic [7:0] t,
                               input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                               input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    vec_t v;
    v.vs = vs; v.hs = hs; v.valid = valid; v.byp = byp;
    v.dm = dm; v.t = t;
    v.r = r; v.g = g; v.b = b;
    v.er = er; v.eg = eg; v.eb = eb;
    return v;
  endfunction

  function automatic vec_t idle(input logic vs);
    return mkv(vs, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
  endfunction

  task automatic compare(input string nm, input logic [8:0] got, input logic [8:0] exp);
    nApplied++;
    if (got !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s at step %0d: got %0d, expected %0d", nm, stepNo, got, exp);
    end
  endtask

  task automatic clearHist();
    for (int i = 0; i < 6; i++) hist[i] = idle(1'b0);
    lastR = 8'd0;
    lastG = 8'd0;
    lastB = 8'd0;
  endtask

  task automatic driveZero();
    bus.i_r = '0; bus.i_g = '0; bus.i_b = '0;
    bus.i_hsync = 1'b0; bus.i_vsync = 1'b0;
    bus.i_transmittance = '0; bus.i_dark_max = '0; bus.i_data_valid = 1'b0;
`ifdef DCP_RECOVER_BYPASS_EN
    bus.i_bypass = 1'b0;
`endif
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v;
    bus.i_r = v.r;
    bus.i_g = v.g;
    bus.i_b = v.b;
    bus.i_hsync = v.hs;
    bus.i_vsync = v.vs;
    bus.i_transmittance = hist[3].t;
    bus.i_dark_max = hist[3].dm;
    bus.i_data_valid = hist[3].valid;
`ifdef DCP_RECOVER_BYPASS_EN
    bus.i_bypass = hist[3].byp;
`endif
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    @(posedge pixelclk);
    #1;
    stepNo++;
    e = hist[5];
    compare({tag, "/valid"}, {8'd0, bus.o_data_valid}, {8'd0, e.valid});
    compare({tag, "/vsync"}, {8'd0, bus.o_vsync}, {8'd0, e.vs});
    compare({tag, "/hsync"}, {8'd0, bus.o_hsync}, {8'd0, e.hs});
    if (e.valid) begin
      compare({tag, "/r"}, {1'b0, bus.o_r}, {1'b0, e.er});
      compare({tag, "/g"}, {1'b0, bus.o_g}, {1'b0, e.eg});
      compare({tag, "/b"}, {1'b0, bus.o_b}, {1'b0, e.eb});
      lastR = e.er;
      lastG = e.eg;
      lastB = e.eb;
    end else begin
      compare({tag, "/hold_r"}, {1'b0, bus.o_r}, {1'b0, lastR});
      compare({tag, "/hold_g"}, {1'b0, bus.o_g}, {1'b0, lastG});
      compare({tag, "/hold_b"}, {1'b0, bus.o_b}, {1'b0, lastB});
    end
  endtask

  initial begin
    // Frame 1 (A=200 latched on its vsync edge), then frame 2 (A=150)
    seg1.push_back(idle(1'b0));
    seg1.push_back(idle(1'b0));
    seg1.push_back(mkv(1, 0, 1, 0, 8'd200, 8'd255, 8'd10,  8'd100, 8'd250, 8'd10,  8'd100, 8'd250));
    seg1.push_back(mkv(0, 1, 1, 0, 8'd200, 8'd128, 8'd100, 8'd250, 8'd200, 8'd0,   8'd255, 8'd200));
    seg1.push_back(idle(1'b0));
    seg1.push_back(mkv(0, 0, 1, 0, 8'd150, 8'd10,  8'd190, 8'd200, 8'd0,   8'd101, 8'd200, 8'd0));
    seg1.push_back(mkv(0, 0, 1, 0, 8'd150, 8'd0,   8'd200, 8'd210, 8'd195, 8'd200, 8'd255, 8'd150));
    seg1.push_back(mkv(0, 1, 1, 0, 8'd150, 8'd64,  8'd50,  8'd220, 8'd205, 8'd0,   8'd255, 8'd219));
    seg1.push_back(mkv(0, 0, 1, 0, 8'd150, 8'd200, 8'd180, 8'd210, 8'd0,   8'd174, 8'd212, 8'd0));
`ifdef DCP_RECOVER_BYPASS_EN
    seg1.push_back(mkv(0, 0, 1, 1, 8'd150, 8'd64,  8'd50,  8'd50,  8'd50,  8'd50,  8'd50,  8'd50));
    seg1.push_back(mkv(0, 0, 1, 0, 8'd150, 8'd64,  8'd50,  8'd50,  8'd50,  8'd0,   8'd0,   8'd0));
`endif
    for (int i = 0; i < 3; i++) seg1.push_back(idle(1'b0));
    seg1.push_back(mkv(1, 0, 1, 0, 8'd150, 8'd128, 8'd100, 8'd150, 8'd200, 8'd50,  8'd150, 8'd249));
    seg1.push_back(mkv(1, 0, 1, 0, 8'd90,  8'd128, 8'd160, 8'd140, 8'd150, 8'd169, 8'd130, 8'd150));
    for (int i = 0; i < 6; i++) seg1.push_back(idle(1'b0));

    // Valid pass-through stream that is in flight when reset hits
    for (int i = 0; i < 6; i++)
      segPre.push_back(mkv(0, 0, 1, 0, 8'd0, 8'd255, 8'd11, 8'd22, 8'd33, 8'd11, 8'd22, 8'd33));

    // After reset: A back to 255 until the next vsync edge, then A=100
    segPost.push_back(idle(1'b0));
    segPost.push_back(mkv(0, 0, 1, 0, 8'd77,  8'd128, 8'd250, 8'd255, 8'd200, 8'd245, 8'd255, 8'd145));
    segPost.push_back(idle(1'b0));
    segPost.push_back(idle(1'b0));
    segPost.push_back(mkv(1, 0, 1, 0, 8'd100, 8'd128, 8'd100, 8'd50,  8'd120, 8'd100, 8'd0,   8'd139));
    for (int i = 0; i < 6; i++) segPost.push_back(idle(1'b0));

    $display("[TB] starting dcp_recover directed vectors");
    driveZero();
    clearHist();
    reset = 1'b1;
    repeat (2) @(posedge pixelclk);
    #1;
    compare("reset/r", {1'b0, bus.o_r}, 9'd0);
    compare("reset/g", {1'b0, bus.o_g}, 9'd0);
    compare("reset/b", {1'b0, bus.o_b}, 9'd0);
    compare("reset/valid", {8'd0, bus.o_data_valid}, 9'd0);
    compare("reset/vsync", {8'd0, bus.o_vsync}, 9'd0);
    compare("reset/hsync", {8'd0, bus.o_hsync}, 9'd0);
    reset = 1'b0;

    foreach (seg1[i]) begin
      applyStimulus(seg1[i]);
      checkOutput("frames");
    end

    foreach (segPre[i]) begin
      applyStimulus(segPre[i]);
      checkOutput("prereset");
    end

    // Asynchronous reset mid-line while valid pixels are in flight
    #2 reset = 1'b1;
    #1;
    compare("midrst/r", {1'b0, bus.o_r}, 9'd0);
    compare("midrst/g", {1'b0, bus.o_g}, 9'd0);
    compare("midrst/b", {1'b0, bus.o_b}, 9'd0);
    compare("midrst/valid", {8'd0, bus.o_data_valid}, 9'd0);
    @(posedge pixelclk);
    #1;
    driveZero();
    clearHist();
    reset = 1'b0;

    foreach (segPost[i]) begin
      applyStimulus(segPost[i]);
      checkOutput("postreset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule
